// File: rtl/arm_dmem_ws.sv
// Data memory for the stalling/multicycle ARM core.
// req/ready/done handshake, WAIT wait states, word and byte (LDRB/STRB) access,
// with misaligned and out-of-range accesses reported on err.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, accepts req and latches the access
// BUSY  | counting down the wait states, ready=0
// RESP  | done=1 for one cycle; a store commits on the edge leaving RESP
module arm_dmem_ws #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 64,
  parameter int    WAIT      = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic              byte_en,
  input  logic [31:0]       a,
  input  logic [DATA_W-1:0] wd,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rd,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       a_q, a_d;
  logic              we_q, we_d;
  logic              be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Resolved access: live inputs while IDLE (needed when WAIT=0 goes straight
  // to RESP on the accept edge), latched copy in every other state.
  logic [31:0]       acc_a;
  logic              acc_we;
  logic              acc_be;
  logic [LB-1:0]     lane;
  logic [AW-1:0]     idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic [DATA_W-1:0] word;
  logic [7:0]        byte_sel;
  logic [DATA_W-1:0] byte_ext;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              load_resp;

  // Decode the current access: lane/index, fault detection and read data.
  always_comb begin
    acc_a        = (state_q == IDLE) ? a       : a_q;
    acc_we       = (state_q == IDLE) ? we      : we_q;
    acc_be       = (state_q == IDLE) ? byte_en : be_q;
    lane         = acc_a[LB-1:0];
    idx          = acc_a[LB +: AW];
    misaligned   = ~acc_be & (lane != '0);
    // The index compare only matters for non-power-of-two DEPTH.
    out_of_range = (32'(idx) >= 32'(DEPTH)) | ((acc_a >> (LB + AW)) != 32'd0);
    fault        = misaligned | out_of_range;
    word         = mem_q[idx];
    byte_sel     = word[{lane, 3'b000} +: 8];
    byte_ext     = {{(DATA_W-8){1'b0}}, byte_sel};
  end

  // Store data: read-modify-write merges a byte store into the existing word.
  always_comb begin
    mem_wdata = word;
    for (int i = 0; i < NB; i++) begin
      if (!acc_be) begin
        mem_wdata[8*i +: 8] = wd_q[8*i +: 8];
      end else if (lane == LB'(i)) begin
        mem_wdata[8*i +: 8] = wd_q[7:0];
      end
    end
    mem_wr = (state_q == RESP) & we_q & ~fault;
  end

  // Memory array: no reset; a store lands on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  // Next-state, handshake outputs and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    we_d      = we_q;
    be_d      = be_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    err_d     = err_q;
    ready     = 1'b0;
    done      = 1'b0;
    load_resp = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          a_d   = a;
          we_d  = we;
          be_d  = byte_en;
          wd_d  = wd;
          cnt_d = 4'(WAIT);
          if (WAIT == 0) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // rd/err are captured on the edge entering RESP and held until the next one.
    if (load_resp) begin
      err_d = fault;
      if (fault || acc_we) begin
        rd_d = '0;
      end else if (acc_be) begin
        rd_d = byte_ext;
      end else begin
        rd_d = word;
      end
    end
  end

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      be_q    <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign rd  = rd_q;
  assign err = err_q & done;

endmodule

// File: tb/tb_arm_dmem_ws.sv
// Bench for arm_dmem_ws: four instances with WAIT = 2, 0, 1, 3 share the
// stimulus bus; req is steered to the selected instance.
module tb_arm_dmem_ws;

  localparam int NI    = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        byte_en = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  int          sel = 0;

  logic [3:0]  req_v;
  logic [3:0]  ready_v, done_v, err_v;
  logic [31:0] rd_v [NI];

  logic [31:0] model [NI][DEPTH];
  int n_chk = 0, n_fail = 0, acc_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  assign req_v = req ? (4'b0001 << sel) : 4'b0000;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    arm_dmem_ws #(
      .DATA_W(32), .DEPTH(DEPTH),
      .WAIT(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 1 : 3),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req_v[g]), .we(we), .byte_en(byte_en),
      .a(a), .wd(wd), .ready(ready_v[g]), .done(done_v[g]), .rd(rd_v[g]), .err(err_v[g])
    );
  end

  // Count every done pulse of every instance, sampled mid-cycle.
  always @(negedge clk) done_cnt += int'($countones(done_v));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : (k == 2) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access on instance k, checked against the reference model.
  task automatic access(input int k, input bit w, input bit b, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdo, output logic erro);
    int n;
    int sh;
    bit flt;
    logic [31:0] cur, exp_rd;
    sel = k;
    n = 0;
    while (ready_v[k] !== 1'b1 && n < 50) begin step(); n++; end
    chk("ready_before_req", ready_v[k], 1);
    req = 1'b1; we = w; byte_en = b; a = addr; wd = data;
    step();
    req = 1'b0; we = 1'($urandom); byte_en = 1'($urandom); a = $urandom; wd = $urandom;
    acc_cnt++;
    n = 0;
    while (done_v[k] !== 1'b1 && n < 40) begin step(); n++; end
    chk("latency", n, wait_of(k));
    flt = (!b && (addr % 4 != 0)) || (addr >= 32'(4 * DEPTH));
    sh = 8 * int'(addr % 4);
    exp_rd = '0;
    cur = '0;
    if (!flt) begin
      cur = model[k][int'(addr >> 2)];
      if (!w) exp_rd = b ? ((cur >> sh) & 32'hFF) : cur;
    end
    chk("err", err_v[k], flt);
    if (flt || !w) chk("rd", rd_v[k], exp_rd);
    rdo = rd_v[k];
    erro = err_v[k];
    step();
    chk("done_one_cycle", done_v[k], 0);
    chk("ready_after", ready_v[k], 1);
    chk("err_without_done", err_v[k], 0);
    if (w && !flt) begin
      if (b) cur = (cur & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
      else   cur = data;
      model[k][int'(addr >> 2)] = cur;
    end
  endtask

  initial begin
    logic [31:0] r, prior, addr, prev_addr;
    logic e;
    bit w, b;

    // Reset
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", ready_v[k], 1);
      chk("rst_done", done_v[k], 0);
      chk("rst_err", err_v[k], 0);
      chk("rst_rd", rd_v[k], 0);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    for (int k = 0; k < NI; k++) chk("post_rst_ready", ready_v[k], 1);

    // Fill every word of every instance so the model is fully defined.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++)
        access(k, 1'b1, 1'b0, 32'(4 * i), $urandom, r, e);

    // Word store/load with WAIT=2
    access(0, 1'b1, 1'b0, 32'h10, 32'h11223344, r, e);
    chk("t1_store_err", e, 0);
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, r, e);
    chk("t1_load_rd", r, 32'h11223344);

    // Byte store and byte load
    access(0, 1'b1, 1'b1, 32'h13, 32'h5A5A5AAB, r, e);
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, r, e);
    chk("t2_word_after_byte", r, 32'hAB223344);
    access(0, 1'b0, 1'b1, 32'h12, 32'h0, r, e);
    chk("t2_byte_load", r, 32'h00000022);

    // Faults
    access(0, 1'b0, 1'b0, 32'h0E, 32'h0, r, e);
    chk("t3_misaligned_err", e, 1);
    chk("t3_misaligned_rd", r, 0);
    prior = model[0][63];
    access(0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, r, e);
    chk("t3_range_err", e, 1);
    access(0, 1'b0, 1'b0, 32'hFC, 32'h0, r, e);
    chk("t3_last_word_unchanged", r, prior);

    // Reset during BUSY aborts the store
    prior = model[0][8];
    sel = 0;
    req = 1'b1; we = 1'b1; byte_en = 1'b0; a = 32'h20; wd = 32'hDEADBEEF;
    step();
    req = 1'b0;
    chk("t4_busy_not_ready", ready_v[0], 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_abort_ready", ready_v[0], 1);
    chk("t4_abort_done", done_v[0], 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("t4_release_ready", ready_v[0], 1);
    chk("t4_release_done", done_v[0], 0);
    access(0, 1'b0, 1'b0, 32'h20, 32'h0, r, e);
    chk("t4_store_discarded", r, prior);

    // req held high with WAIT=0: one accept every second cycle
    sel = 1;
    for (int n = 0; n < 10 && ready_v[1] !== 1'b1; n++) step();
    req = 1'b1; we = 1'b0; byte_en = 1'b0; a = 32'h4;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("t5_done", done_v[1], (j % 2 == 1) ? 1 : 0);
      chk("t5_ready", ready_v[1], (j % 2 == 1) ? 0 : 1);
      if (j % 2 == 1) begin
        acc_cnt++;
        chk("t5_rd", rd_v[1], model[1][1]);
      end
    end
    req = 1'b0;
    step();

    // Random mix against the reference model for WAIT in {0,1,3}
    prev_addr = 32'h0;
    for (int k = 1; k < NI; k++) begin
      for (int i = 0; i < 80; i++) begin
        w = 1'($urandom);
        b = 1'($urandom);
        if ($urandom_range(0, 3) == 0) addr = prev_addr;
        else addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 255)) << 8);
        access(k, w, b, addr, $urandom, r, e);
        prev_addr = addr;
      end
    end

    step(); step();
    chk("done_count_eq_accepts", done_cnt, acc_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
